a1339_sensor_emulator: RTL

SPI responder that emulates up to NUMBER_OF_SENSORS A1339 angle sensors on a shared SPI bus. It sits on the sensor side of the angle bus: angle_sck, angle_ss_n and angle_mosi come from the platform's A1339 SPI master, and the block drives MISO. The emulator serves synthetic angles from the fabric, which supports hardware-in-the-loop runs of the MSJ platform without motors or magnets. Each sensor slot tracks full revolutions and answers reads one frame late, matching A1339 pipelined behaviour.

---
 rtl/a1339_sensor_emulator.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/a1339_sensor_emulator.sv
// A1339 angle-sensor emulator: SPI mode-3 responder serving fabric angles and
// revolution counts for up to 16 sensor slots, answering each read one frame late.
module a1339_sensor_emulator #(
  parameter int NUMBER_OF_SENSORS = 6
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           sck,
  input  logic [NUMBER_OF_SENSORS-1:0]   ss_n,
  input  logic                           mosi,
  output logic                           miso,
  output logic                           miso_oe,
  input  logic [12*NUMBER_OF_SENSORS-1:0] angles_i,
  output logic                           frame_done,
  output logic [15:0]                    frame_error_count
);

  localparam int N = NUMBER_OF_SENSORS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    DONE    = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  state_t         state_r;
  state_t         state_next_s;

  logic [1:0]     sck_sync_r;
  logic           sck_prev_r;
  logic [1:0]     mosi_sync_r;
  logic [N-1:0]   ss_meta_r;
  logic [N-1:0]   ss_sync_r;

  logic           sck_rise_s;
  logic           sck_fall_s;

  logic           prev_valid_r;
  logic [11:0]    prev_angle_r [N];
  logic [11:0]    turns_r [N];
  logic [N-1:0]   pending_valid_r;
  logic [5:0]     pending_addr_r [N];

  logic [N-1:0]   sel_mask_r;
  logic [4:0]     bit_count_r;
  logic [15:0]    resp_shift_r;
  logic           cmd_write_r;
  logic [5:0]     cmd_addr_r;
  logic           miso_r;
  logic           miso_oe_r;
  logic           frame_done_r;
  logic [15:0]    error_count_r;

  logic [4:0]     low_count_s;
  logic [11:0]    low_angle_s;
  logic [11:0]    low_turns_s;
  logic           low_valid_s;
  logic [5:0]     low_addr_s;
  logic [15:0]    resp_s;
  logic           others_low_s;
  logic           sel_high_s;

  logic           start_s;
  logic           illegal_s;
  logic           abort_s;
  logic           complete_s;
  logic           shift_in_s;
  logic           shift_out_s;
  logic           zero_out_s;

  assign sck_rise_s   = sck_sync_r[1] & ~sck_prev_r;
  assign sck_fall_s   = ~sck_sync_r[1] & sck_prev_r;
  assign others_low_s = |(~ss_sync_r & ~sel_mask_r);
  assign sel_high_s   = |(ss_sync_r & sel_mask_r);

  assign miso              = miso_r;
  assign miso_oe           = miso_oe_r;
  assign frame_done        = frame_done_r;
  assign frame_error_count = error_count_r;

  // Two-stage synchronisers for the asynchronous SPI pins; idle values match a quiet bus
  always_ff @(posedge clock) begin
    if (reset) begin
      sck_sync_r  <= 2'b11;
      sck_prev_r  <= 1'b1;
      mosi_sync_r <= 2'b00;
      ss_meta_r   <= '1;
      ss_sync_r   <= '1;
    end else begin
      sck_sync_r  <= {sck_sync_r[0], sck};
      sck_prev_r  <= sck_sync_r[1];
      mosi_sync_r <= {mosi_sync_r[0], mosi};
      ss_meta_r   <= ss_n;
      ss_sync_r   <= ss_meta_r;
    end
  end

  // Revolution tracking on every slot, every cycle; first cycle after reset only seeds prev
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_valid_r <= 1'b0;
      for (int k = 0; k < N; k++) begin
        prev_angle_r[k] <= 12'd0;
        turns_r[k]      <= 12'd0;
      end
    end else begin
      prev_valid_r <= 1'b1;
      for (int k = 0; k < N; k++) begin
        prev_angle_r[k] <= angles_i[12*k +: 12];
        if (prev_valid_r) begin
          if ((prev_angle_r[k] >= 12'd3072) && (angles_i[12*k +: 12] < 12'd1024)) begin
            turns_r[k] <= turns_r[k] + 12'd1;
          end else if ((prev_angle_r[k] < 12'd1024) && (angles_i[12*k +: 12] >= 12'd3072)) begin
            turns_r[k] <= turns_r[k] - 12'd1;
          end
        end
      end
    end
  end

  // Selected-slot lookup and the response word that a starting frame will shift out
  always_comb begin
    low_count_s = 5'd0;
    low_angle_s = 12'd0;
    low_turns_s = 12'd0;
    low_valid_s = 1'b0;
    low_addr_s  = 6'd0;
    for (int k = 0; k < N; k++) begin
      if (!ss_sync_r[k]) begin
        low_count_s = low_count_s + 5'd1;
        low_angle_s = angles_i[12*k +: 12];
        low_turns_s = turns_r[k];
        low_valid_s = pending_valid_r[k];
        low_addr_s  = pending_addr_r[k];
      end else begin
        low_count_s = low_count_s;
      end
    end
    resp_s = 16'h0000;
    if (low_valid_s) begin
      case (low_addr_s)
        6'h20:   resp_s = {4'h0, low_angle_s};
        6'h2C:   resp_s = {4'h0, low_turns_s};
        default: resp_s = 16'h0000;
      endcase
    end else begin
      resp_s = 16'h0000;
    end
  end

  // Frame state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and per-cycle frame strobes
  always_comb begin
    state_next_s = state_r;
    start_s      = 1'b0;
    illegal_s    = 1'b0;
    abort_s      = 1'b0;
    complete_s   = 1'b0;
    shift_in_s   = 1'b0;
    shift_out_s  = 1'b0;
    zero_out_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (low_count_s == 5'd1) begin
          start_s      = 1'b1;
          state_next_s = SHIFT;
        end else if (low_count_s > 5'd1) begin
          illegal_s    = 1'b1;
          state_next_s = ILLEGAL;
        end else begin
          state_next_s = IDLE;
        end
      end
      SHIFT: begin
        if (others_low_s) begin
          illegal_s    = 1'b1;
          state_next_s = ILLEGAL;
        end else if (sel_high_s) begin
          abort_s      = 1'b1;
          state_next_s = IDLE;
        end else if (sck_rise_s) begin
          shift_in_s   = 1'b1;
          state_next_s = (bit_count_r == 5'd15) ? DONE : SHIFT;
        end else if (sck_fall_s) begin
          shift_out_s  = 1'b1;
        end else begin
          state_next_s = SHIFT;
        end
      end
      DONE: begin
        if (sel_high_s) begin
          complete_s   = 1'b1;
          state_next_s = IDLE;
        end else if (sck_fall_s) begin
          zero_out_s   = 1'b1;
        end else begin
          state_next_s = DONE;
        end
      end
      ILLEGAL: begin
        if (&ss_sync_r) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = ILLEGAL;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Shift datapath, pending-read bookkeeping and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      sel_mask_r      <= '0;
      bit_count_r     <= 5'd0;
      resp_shift_r    <= 16'h0000;
      cmd_write_r     <= 1'b0;
      cmd_addr_r      <= 6'd0;
      miso_r          <= 1'b1;
      miso_oe_r       <= 1'b0;
      frame_done_r    <= 1'b0;
      error_count_r   <= 16'h0000;
      pending_valid_r <= '0;
      for (int k = 0; k < N; k++) begin
        pending_addr_r[k] <= 6'd0;
      end
    end else begin
      frame_done_r <= complete_s;
      miso_oe_r    <= (state_next_s == SHIFT) || (state_next_s == DONE);
      if (start_s) begin
        sel_mask_r   <= ~ss_sync_r;
        bit_count_r  <= 5'd0;
        resp_shift_r <= resp_s;
        miso_r       <= 1'b1;
      end else if (shift_in_s) begin
        bit_count_r <= bit_count_r + 5'd1;
        if (bit_count_r == 5'd0) begin
          cmd_write_r <= mosi_sync_r[1];
        end
        if ((bit_count_r >= 5'd2) && (bit_count_r <= 5'd7)) begin
          cmd_addr_r <= {cmd_addr_r[4:0], mosi_sync_r[1]};
        end
      end else if (shift_out_s) begin
        miso_r       <= resp_shift_r[15];
        resp_shift_r <= {resp_shift_r[14:0], 1'b0};
      end else if (zero_out_s) begin
        miso_r <= 1'b0;
      end else if (state_r == IDLE) begin
        miso_r <= 1'b1;
      end
      if ((abort_s || illegal_s) && (error_count_r != 16'hFFFF)) begin
        error_count_r <= error_count_r + 16'h0001;
      end
      if (complete_s) begin
        for (int k = 0; k < N; k++) begin
          if (sel_mask_r[k]) begin
            if (cmd_write_r) begin
              pending_valid_r[k] <= 1'b0;
            end else begin
              pending_valid_r[k] <= 1'b1;
              pending_addr_r[k]  <= cmd_addr_r;
            end
          end
        end
      end
    end
  end

endmodule
